// File: rtl/bcd_7segment_pkg.sv
// Shared glyph and segment-index constants for the BCD seven-segment decoder.
// Glyphs are active-high, packed ABCDEFG with segment A in the MSB.
package bcd_7segment_pkg;

    localparam int SEG_W = 7;

    localparam int SEG_IDX_A = 6;
    localparam int SEG_IDX_B = 5;
    localparam int SEG_IDX_C = 4;
    localparam int SEG_IDX_D = 3;
    localparam int SEG_IDX_E = 2;
    localparam int SEG_IDX_F = 1;
    localparam int SEG_IDX_G = 0;

    localparam logic [SEG_W-1:0] SEG_0 = 7'b1111110;
    localparam logic [SEG_W-1:0] SEG_1 = 7'b0110000;
    localparam logic [SEG_W-1:0] SEG_2 = 7'b1101101;
    localparam logic [SEG_W-1:0] SEG_3 = 7'b1111001;
    localparam logic [SEG_W-1:0] SEG_4 = 7'b0110011;
    localparam logic [SEG_W-1:0] SEG_5 = 7'b1011011;
    localparam logic [SEG_W-1:0] SEG_6 = 7'b1011111;
    localparam logic [SEG_W-1:0] SEG_7 = 7'b1110000;
    localparam logic [SEG_W-1:0] SEG_8 = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_9 = 7'b1111011;
    localparam logic [SEG_W-1:0] SEG_A = 7'b1110111;
    localparam logic [SEG_W-1:0] SEG_B = 7'b0011111;
    localparam logic [SEG_W-1:0] SEG_C = 7'b1001110;
    localparam logic [SEG_W-1:0] SEG_D = 7'b0111101;
    localparam logic [SEG_W-1:0] SEG_E = 7'b1001111;
    localparam logic [SEG_W-1:0] SEG_F = 7'b1000111;

    localparam logic [SEG_W-1:0] SEG_BLANK = '0;
    localparam logic [SEG_W-1:0] SEG_ALL =
        SEG_W'((1 << SEG_IDX_A) | (1 << SEG_IDX_B) | (1 << SEG_IDX_C) |
               (1 << SEG_IDX_D) | (1 << SEG_IDX_E) | (1 << SEG_IDX_F) |
               (1 << SEG_IDX_G));

endpackage

// File: rtl/bcd_7segment_rom.sv
// Combinational digit-to-glyph lookup with out-of-range detection.
// Define BCD_7SEG_HEX_EN to show hex glyphs for codes 10-15 instead of blank.
import bcd_7segment_pkg::*;

module bcd_7segment_rom (
    input  logic [3:0]       Binary_Num,
    output logic [SEG_W-1:0] glyph,
    output logic             invalid
);

    always_comb begin
        glyph   = SEG_BLANK;
        invalid = (Binary_Num > 4'd9);
        case (Binary_Num)
            4'd0:    glyph = SEG_0;
            4'd1:    glyph = SEG_1;
            4'd2:    glyph = SEG_2;
            4'd3:    glyph = SEG_3;
            4'd4:    glyph = SEG_4;
            4'd5:    glyph = SEG_5;
            4'd6:    glyph = SEG_6;
            4'd7:    glyph = SEG_7;
            4'd8:    glyph = SEG_8;
            4'd9:    glyph = SEG_9;
`ifdef BCD_7SEG_HEX_EN
            4'd10:   glyph = SEG_A;
            4'd11:   glyph = SEG_B;
            4'd12:   glyph = SEG_C;
            4'd13:   glyph = SEG_D;
            4'd14:   glyph = SEG_E;
            4'd15:   glyph = SEG_F;
`endif
            default: glyph = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_7segment.sv
// Registered BCD-to-seven-segment decoder with lamp test, blanking and ripple blanking.
// Hex glyphs for codes 10-15 are enabled by defining BCD_7SEG_HEX_EN.
import bcd_7segment_pkg::*;

module bcd_7segment #(
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       Binary_Num,
    input  logic             lamp_test,
    input  logic             blank,
    input  logic             rbi,
    output logic [SEG_W-1:0] Segment,
    output logic             rbo,
    output logic             invalid
);

    logic [SEG_W-1:0] rom_glyph;
    logic             rom_invalid;
    logic [SEG_W-1:0] seg_next;
    logic [SEG_W-1:0] seg_drive_next;
    logic             rbo_next;
    logic [SEG_W-1:0] seg_reg;
    logic             rbo_reg;
    logic             invalid_reg;

    bcd_7segment_rom u_rom (
        .Binary_Num (Binary_Num),
        .glyph      (rom_glyph),
        .invalid    (rom_invalid)
    );

    always_comb begin
        seg_next = rom_glyph;
        rbo_next = 1'b0;
        if (lamp_test) begin
            seg_next = SEG_ALL;
        end else if (blank) begin
            seg_next = SEG_BLANK;
        end else if (rbi && (Binary_Num == 4'd0)) begin
            seg_next = SEG_BLANK;
            rbo_next = 1'b1;
        end
    end

    // Polarity is applied before the register so the pins never glitch.
    for (genvar gi = 0; gi < SEG_W; gi++) begin : g_polarity
        assign seg_drive_next[gi] = ACTIVE_LOW ? ~seg_next[gi] : seg_next[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_reg     <= ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
            rbo_reg     <= 1'b0;
            invalid_reg <= 1'b0;
        end else begin
            seg_reg     <= seg_drive_next;
            rbo_reg     <= rbo_next;
            invalid_reg <= rom_invalid;
        end
    end

    assign Segment = seg_reg;
    assign rbo     = rbo_reg;
    assign invalid = invalid_reg;

endmodule

// File: tb/tb_bcd_7segment.sv
// Self-checking bench for bcd_7segment: one common-cathode and one common-anode instance.
// Define BCD_7SEG_HEX_EN for both RTL and bench to check the hex glyph build.
module tb_bcd_7segment;

    typedef struct {
        logic [3:0] num;
        logic       lt;
        logic       bl;
        logic       rbi;
        logic [6:0] seg;
        logic       rbo;
        logic       inv;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] Binary_Num = 4'd0;
    logic       lamp_test = 1'b0;
    logic       blank = 1'b0;
    logic       rbi = 1'b0;
    logic [6:0] seg_hi, seg_lo;
    logic       rbo_hi, rbo_lo, inv_hi, inv_lo;

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    bcd_7segment #(.ACTIVE_LOW(1'b0)) dut_hi (
        .clk(clk), .rst_n(rst_n), .Binary_Num(Binary_Num), .lamp_test(lamp_test),
        .blank(blank), .rbi(rbi), .Segment(seg_hi), .rbo(rbo_hi), .invalid(inv_hi)
    );

    bcd_7segment #(.ACTIVE_LOW(1'b1)) dut_lo (
        .clk(clk), .rst_n(rst_n), .Binary_Num(Binary_Num), .lamp_test(lamp_test),
        .blank(blank), .rbi(rbi), .Segment(seg_lo), .rbo(rbo_lo), .invalid(inv_lo)
    );

    function automatic logic [6:0] ref_glyph(input logic [3:0] n);
        case (n)
            4'd0: return 7'b1111110;
            4'd1: return 7'b0110000;
            4'd2: return 7'b1101101;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0110011;
            4'd5: return 7'b1011011;
            4'd6: return 7'b1011111;
            4'd7: return 7'b1110000;
            4'd8: return 7'b1111111;
            4'd9: return 7'b1111011;
`ifdef BCD_7SEG_HEX_EN
            4'd10: return 7'b1110111;
            4'd11: return 7'b0011111;
            4'd12: return 7'b1001110;
            4'd13: return 7'b0111101;
            4'd14: return 7'b1001111;
            4'd15: return 7'b1000111;
`endif
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic vec_t mk(input logic [3:0] n, input logic lt, input logic bl,
                                input logic r, input logic [6:0] s, input logic ro);
        vec_t v;
        v.num = n; v.lt = lt; v.bl = bl; v.rbi = r;
        v.seg = s; v.rbo = ro; v.inv = (n > 4'd9);
        return v;
    endfunction

    task automatic check_now(input string name, input logic [6:0] s_hi, input logic [6:0] s_lo,
                             input logic ro, input logic inv);
        checks++;
        $display("%0t %s: num=%0d seg=%b seg_al=%b rbo=%b inv=%b", $time, name,
                 Binary_Num, seg_hi, seg_lo, rbo_hi, inv_hi);
        if (seg_hi !== s_hi || seg_lo !== s_lo || rbo_hi !== ro || rbo_lo !== ro ||
            inv_hi !== inv || inv_lo !== inv) begin
            errors++;
            $display("FAIL %s: got seg=%b seg_al=%b rbo=%b/%b inv=%b/%b exp seg=%b seg_al=%b rbo=%b inv=%b",
                     name, seg_hi, seg_lo, rbo_hi, rbo_lo, inv_hi, inv_lo, s_hi, s_lo, ro, inv);
        end
    endtask

    // Scoreboard: entry pushed at the negedge drive is due just after the next rising edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            vec_t e;
            e = exp_q.pop_front();
            check_now("vec", e.seg, ~e.seg, e.rbo, e.inv);
        end
    end

    task automatic drive(input vec_t v);
        @(negedge clk);
        Binary_Num = v.num;
        lamp_test  = v.lt;
        blank      = v.bl;
        rbi        = v.rbi;
        exp_q.push_back(v);
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending exp 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        // Glyph sweep, one digit per clock.
        for (int i = 0; i < 10; i++) vecs.push_back(mk(4'(i), 0, 0, 0, ref_glyph(4'(i)), 0));
        for (int i = 10; i < 16; i++) vecs.push_back(mk(4'(i), 0, 0, 0, ref_glyph(4'(i)), 0));
        vecs.push_back(mk(4'd0, 0, 0, 1, 7'b0000000, 1));
        vecs.push_back(mk(4'd0, 0, 0, 0, 7'b1111110, 0));
        vecs.push_back(mk(4'd7, 0, 0, 1, 7'b1110000, 0));
        vecs.push_back(mk(4'd5, 1, 1, 0, 7'b1111111, 0));
        vecs.push_back(mk(4'd5, 0, 1, 0, 7'b0000000, 0));
        vecs.push_back(mk(4'd5, 0, 0, 0, 7'b1011011, 0));
        vecs.push_back(mk(4'd0, 1, 0, 1, 7'b1111111, 0));
        vecs.push_back(mk(4'd0, 0, 1, 1, 7'b0000000, 0));
        vecs.push_back(mk(4'd12, 1, 0, 0, 7'b1111111, 0));
        vecs.push_back(mk(4'd13, 0, 1, 0, 7'b0000000, 0));
        vecs.push_back(mk(4'd12, 0, 0, 1, ref_glyph(4'd12), 0));

        repeat (3) @(posedge clk);
        #1;
        check_now("reset_hold", 7'b0000000, 7'b1111111, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_now("reset_release", 7'b0000000, 7'b1111111, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) drive(vecs[i]);
        drain();

        // Asynchronous reset between edges while showing 8.
        drive(mk(4'd8, 0, 0, 0, 7'b1111111, 0));
        drain();
        rst_n = 1'b0;
        #1;
        check_now("async_reset", 7'b0000000, 7'b1111111, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_now("reset_held_edge", 7'b0000000, 7'b1111111, 1'b0, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        drive(mk(4'd1, 0, 0, 0, 7'b0110000, 0));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_7segment.md
# bcd_7segment

Registered BCD-to-seven-segment decoder for driving one digit of a numeric LED display. Each clock it converts a 4-bit BCD digit into the seven segment enables A–G. It also supports lamp test, forced blanking and ripple (leading-zero) blanking, so several instances can be chained across a multi-digit display. It sits between the datapath's BCD digit registers and the display pin drivers.

## Interface
- `ACTIVE_LOW`, default 0: 0 = segment lit by driving 1 (common cathode); 1 = all `Segment` bits inverted at the output register (common anode).
- `clk` input 1: single clock; all outputs registered on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `Binary_Num` input 4: BCD digit to display; legal values 0–9.
- `lamp_test` input 1: force all seven segments lit.
- `blank` input 1: force all segments off.
- `rbi` input 1: ripple-blank in; blank this digit if it is zero.
- `Segment` output 7: segment enables, `Segment[6]`=A, `[5]`=B, `[4]`=C, `[3]`=D, `[2]`=E, `[1]`=F, `[0]`=G (ABCDEFG, MSB first).
- `rbo` output 1: ripple-blank out; 1 when this digit was blanked by ripple blanking. Feeds the next lower digit's `rbi`.
- `invalid` output 1: `Binary_Num` was 10–15 on the sampled edge.

## Operation
- Glyphs (active-high ABCDEFG):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
- Priority, highest first:
  - `lamp_test` → 1111111.
  - `blank` → 0000000.
  - `rbi`=1 and `Binary_Num`=0 → 0000000, with `rbo`=1.
  - Otherwise the glyph for `Binary_Num`.
- `rbo`=1 only in the ripple-blank case; 0 in all other cases, including lamp test and forced blank.
- `invalid` follows `Binary_Num`≥10 regardless of `lamp_test` or `blank`.
- Codes 10–15 with no override: blank (0000000), unless `BCD_7SEG_HEX_EN` is defined (see Configuration).
- `ACTIVE_LOW` inversion applies to `Segment` only, never to `rbo` or `invalid`.

## Timing
- Latency: exactly one clock. Inputs sampled on rising edge N appear on the outputs after edge N.
- No handshake; a new digit is accepted every cycle.
- Reset values, asserted asynchronously while `rst_n`=0:
  - `Segment` all segments off: 0000000, or 1111111 when `ACTIVE_LOW`=1.
  - `rbo`=0, `invalid`=0.
- Release of `rst_n` is synchronous to `clk`. The first decoded value appears after the first rising edge with `rst_n`=1.
- Reset mid-stream: outputs go off immediately; no pending state is retained.
- Chained ripple blanking: each stage adds one cycle between `rbi` and `rbo`. Multi-digit chains must pipeline-align their digits accordingly.

## Configuration
- `BCD_7SEG_HEX_EN` defined: codes 10–15 decode to hex glyphs:
  - A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
  - `invalid` still asserts for these codes.
- Not defined: codes 10–15 display blank.

## Structure
- Shared package `bcd_7segment_pkg`:
  - 7-bit segment glyph constants SEG_0..SEG_9, SEG_A..SEG_F, SEG_BLANK, SEG_ALL.
  - Segment bit index constants for A–G.
- One combinational sub-module `bcd_7segment_rom`: `Binary_Num` → raw glyph plus `invalid`; owns the `BCD_7SEG_HEX_EN` selection.
- Top level adds the priority override logic, `ACTIVE_LOW` inversion and the output registers.

## Test plan
- Hold `rst_n`=0 → `Segment`=0000000, `rbo`=0, `invalid`=0. Release, then step `Binary_Num` 0..9 one per clock → 1111110, 0110000, 1101101, 1111001, 0110011, 1011011, 1011111, 1110000, 1111111, 1111011, each one cycle after its input.
- `Binary_Num`=12 → `invalid`=1, `Segment`=0000000 (or 1001110 with `BCD_7SEG_HEX_EN`).
- `Binary_Num`=0, `rbi`=1 → `Segment`=0000000, `rbo`=1. Same digit with `rbi`=0 → 1111110, `rbo`=0.
- `Binary_Num`=5 with `lamp_test`=1 and `blank`=1 → 1111111. Drop `lamp_test` → 0000000. Drop `blank` → 1011011.
- `ACTIVE_LOW`=1, `Binary_Num`=1 → `Segment`=1001111. Reset value is 1111111.
- Assert `rst_n`=0 between clock edges while displaying 8 → `Segment` goes off immediately, without waiting for a clock edge.
